// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM states, AXI constants and strobe helper for sram_axi_bridge
package bridge_pkg;
    typedef enum logic [2:0] {IDLE, AR, R, AW, B} state_t;
    localparam int TIMEOUT = 255;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic [3:0] wstrb_gen(input logic [1:0] size, input logic [1:0] addr);
        return size == SIZE_BYTE ? 4'b0001 << addr :
               size == SIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/sram_axi_bridge_if.sv
// sram_axi_bridge_if: single-beat AXI3 bus between the bridge (master) and its slave
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rvalid, awready, wready, bvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rid, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/axi_wstrb_gen.sv
// axi_wstrb_gen: byte-lane strobes for a single-beat store from size and address low bits
module axi_wstrb_gen
    import bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic [3:0] wstrb
);
    assign wstrb = wstrb_gen(size, addr);
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: core inst/data sram-like ports onto one AXI3 master, one transaction in flight.
// Define SRAM_AXI_TIMEOUT_EN to force completion (rdata 0xDEADBEEF, sticky err) on a stuck R/B channel.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              err,
    sram_axi_bridge_if.master axi
);
    state_t      state;
    logic        src_data;
    logic        to_hit;
    logic        idle;
    logic        unused_rid;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // addr_ok is combinational so the grant lands in the same IDLE cycle; masked while rst is high
    assign idle         = state == IDLE && !rst;
    assign data_addr_ok = idle && data_req;
    assign inst_addr_ok = idle && !data_req && inst_req;
    assign inst_rdata   = rdata_q;
    assign data_rdata   = rdata_q;
    assign unused_rid   = ^axi.rid;

    assign axi.arid    = src_data ? ID_DATA : ID_INST;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = '0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.awid    = ID_DATA;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = '0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.wid     = ID_DATA;
    assign axi.wdata   = wdata_q;
    assign axi.wlast   = 1'b1;

    axi_wstrb_gen u_wstrb (
        .size  (size_q),
        .addr  (addr_q[1:0]),
        .wstrb (axi.wstrb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            src_data     <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            axi.arvalid  <= 1'b0;
            axi.rready   <= 1'b0;
            axi.awvalid  <= 1'b0;
            axi.wvalid   <= 1'b0;
            axi.bready   <= 1'b0;
        end else begin
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            case (state)
                IDLE: if (data_req || inst_req) begin
                    src_data    <= data_req;
                    addr_q      <= data_req ? data_addr : inst_addr;
                    size_q      <= data_req && data_size != 2'd3 ? data_size : SIZE_WORD;
                    wdata_q     <= data_wdata;
                    state       <= data_req && data_wr ? AW : AR;
                    axi.arvalid <= !(data_req && data_wr);
                    axi.awvalid <= data_req && data_wr;
                    axi.wvalid  <= data_req && data_wr;
                end
                AR: if (axi.arready) begin
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                    state       <= R;
                end
                R: if (axi.rvalid || to_hit) begin
                    axi.rready   <= 1'b0;
                    rdata_q      <= axi.rvalid ? axi.rdata : 32'hDEADBEEF;
                    inst_data_ok <= !src_data;
                    data_data_ok <= src_data;
                    state        <= IDLE;
                end
                AW: begin
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready) axi.wvalid <= 1'b0;
                    if ((axi.awready || !axi.awvalid) && (axi.wready || !axi.wvalid)) begin
                        axi.bready <= 1'b1;
                        state      <= B;
                    end
                end
                B: if (axi.bvalid || to_hit) begin
                    axi.bready   <= 1'b0;
                    data_data_ok <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_AXI_TIMEOUT_EN
    logic [7:0] cnt;

    assign to_hit = cnt == 8'(TIMEOUT - 1) &&
                    ((state == R && !axi.rvalid) || (state == B && !axi.bvalid));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (state == R || state == B) ? cnt + 8'd1 : 8'd0;
            err <= err || to_hit;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: randomized bench with a behavioural AXI slave and a word-memory reference model
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [31:0] data_addr = '0, data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        err;

    sram_axi_bridge_if axi();

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .err(err), .axi(axi)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0, cyc = 0;
    int inst_ok_cnt = 0, data_ok_cnt = 0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (inst_data_ok) inst_ok_cnt++;
        if (data_data_ok) data_ok_cnt++;
    end

    logic [31:0] slv_mem [int];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] init_word(int w);
        return (32'(w) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction
    function automatic logic [31:0] slv_rd(int w);
        return slv_mem.exists(w) ? slv_mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] ref_rd(int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    // Reference store: writes the naturally aligned 1/2/4-byte field containing the address
    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int w = int'(a[31:2]);
        logic [31:0] cur = ref_rd(w);
        int n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        int lo = sz == 2'd0 ? int'(a[1:0]) : sz == 2'd1 ? (a[1] ? 2 : 0) : 0;
        for (int b = lo; b < lo + n; b++) cur[8*b +: 8] = wd[8*b +: 8];
        ref_mem[w] = cur;
    endtask

    int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    bit r_hang = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit rd_pend = 0, aw_done = 0, w_done = 0, ar_watch = 0, ar_unstable = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, ar_first = '0;
    logic [3:0]  wr_strb = '0, ar_id = '0;
    logic [2:0]  wr_size = '0;
    int aw_hs_cyc = 0, w_hs_cyc = 0;

    // Behavioural AXI slave: decides readies/valids on the falling edge with configurable delays
    initial begin : slave
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rid = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                rd_pend = 0; aw_done = 0; w_done = 0; ar_watch = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (axi.arready) begin
                    axi.arready = 0; rd_pend = 1; r_cnt = 0; ar_watch = 0;
                end else if (axi.arvalid) begin
                    if (!ar_watch) begin ar_watch = 1; ar_first = axi.araddr; end
                    else if (axi.araddr !== ar_first) ar_unstable = 1;
                    if (ar_cnt >= ar_delay) begin
                        axi.arready = 1; rd_addr = axi.araddr; ar_id = axi.arid; ar_cnt = 0;
                    end else ar_cnt++;
                end else if (ar_watch) ar_unstable = 1;
                if (axi.rvalid) axi.rvalid = 0;
                else if (rd_pend && !r_hang) begin
                    if (r_cnt >= r_delay) begin
                        axi.rvalid = 1; axi.rdata = slv_rd(int'(rd_addr[31:2])); axi.rid = ar_id; rd_pend = 0;
                    end else r_cnt++;
                end
                if (axi.awready) begin axi.awready = 0; aw_done = 1; end
                else if (axi.awvalid && !aw_done) begin
                    if (aw_cnt >= aw_delay) begin
                        axi.awready = 1; wr_addr = axi.awaddr; wr_size = axi.awsize; aw_hs_cyc = cyc; aw_cnt = 0;
                    end else aw_cnt++;
                end
                if (axi.wready) begin axi.wready = 0; w_done = 1; end
                else if (axi.wvalid && !w_done) begin
                    if (w_cnt >= w_delay) begin
                        axi.wready = 1; wr_data = axi.wdata; wr_strb = axi.wstrb; w_hs_cyc = cyc; w_cnt = 0;
                    end else w_cnt++;
                end
                if (axi.bvalid) axi.bvalid = 0;
                else if (aw_done && w_done) begin
                    if (b_cnt >= b_delay) begin
                        logic [31:0] cur;
                        cur = slv_rd(int'(wr_addr[31:2]));
                        for (int b = 0; b < 4; b++) if (wr_strb[b]) cur[8*b +: 8] = wr_data[8*b +: 8];
                        slv_mem[int'(wr_addr[31:2])] = cur;
                        axi.bvalid = 1; aw_done = 0; w_done = 0; b_cnt = 0;
                    end else b_cnt++;
                end
            end
        end
    end

    task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
        ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
    endtask

    // One core request; lat counts cycles from the addr_ok cycle (0) to the data_ok cycle
    task automatic do_req(input bit d, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd, output bit ok);
        int n = 0;
        bit got = 0;
        data_req = d; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        inst_req = !d; inst_addr = a;
        while (!got && n < 20) begin
            @(negedge clk);
            got = d ? data_addr_ok : inst_addr_ok;
            @(posedge clk); #1;
            n++;
        end
        data_req = 0; inst_req = 0;
        ok = 0; lat = 1; rd = '0; n = 0;
        while (got && !ok && n < 400) begin
            @(negedge clk);
            if (d ? data_data_ok : inst_data_ok) begin
                ok = 1; rd = d ? data_rdata : inst_rdata;
            end else begin
                @(posedge clk); #1; lat++;
            end
            n++;
        end
        if (ok) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        inst_req = 1; data_req = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin fails++; $display("FAIL reset_addr_ok: got %b expected 00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin fails++; $display("FAIL reset_axi_valid: got %b expected 00000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}); end
        checks++; if ({inst_data_ok, data_data_ok, err} !== 3'b0) begin fails++; $display("FAIL reset_ok_err: got %b expected 000", {inst_data_ok, data_data_ok, err}); end
        checks++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h/%h expected 0", inst_rdata, data_rdata); end
        checks++; if ({axi.arlen, axi.awlen, axi.arburst, axi.awburst, axi.wlast, axi.awid, axi.wid} !== {4'd0, 4'd0, 2'b01, 2'b01, 1'b1, 4'd1, 4'd1}) begin fails++; $display("FAIL reset_constants: got %h", {axi.arlen, axi.awlen, axi.arburst, axi.awburst, axi.wlast, axi.awid, axi.wid}); end
        inst_req = 0; data_req = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_inst_read;
        int lat; logic [31:0] rd; bit ok;
        slv_mem[int'(32'h1FC00000 >> 2)] = 32'h3C08BFAF;
        ref_mem[int'(32'h1FC00000 >> 2)] = 32'h3C08BFAF;
        set_delays(0, 0, 0, 0, 0);
        do_req(0, 0, 2'd2, 32'h1FC00000, '0, lat, rd, ok);
        checks++; if (!ok) begin fails++; $display("FAIL inst_read_done: no inst_data_ok"); end
        checks++; if (lat !== 3) begin fails++; $display("FAIL inst_read_latency: got %0d expected 3", lat); end
        checks++; if (rd !== 32'h3C08BFAF) begin fails++; $display("FAIL inst_read_data: got %h expected 3c08bfaf", rd); end
        checks++; if (ar_id !== 4'd0 || rd_addr !== 32'h1FC00000) begin fails++; $display("FAIL inst_read_ar: got id %0d addr %h expected 0 1fc00000", ar_id, rd_addr); end
    endtask

    task automatic test_arbitration;
        int d_gnt = -1, i_gnt = -1, d_ok = -1, i_ok = -1;
        logic [31:0] d_rd = '0, i_rd = '0;
        logic [3:0] ids [$];
        bit prev_arv = 0;
        set_delays(0, 0, 0, 0, 0);
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h2000;
        inst_req = 1; inst_addr = 32'h3000;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (data_addr_ok && d_gnt < 0) d_gnt = k;
            if (inst_addr_ok && i_gnt < 0) i_gnt = k;
            if (data_data_ok) begin d_ok = k; d_rd = data_rdata; end
            if (inst_data_ok) begin i_ok = k; i_rd = inst_rdata; end
            if (axi.arvalid && !prev_arv) ids.push_back(axi.arid);
            prev_arv = axi.arvalid;
            @(posedge clk); #1;
            if (k == d_gnt) data_req = 0;
            if (k == i_gnt) inst_req = 0;
        end
        data_req = 0; inst_req = 0;
        checks++; if (d_gnt !== 0) begin fails++; $display("FAIL arb_data_first: got grant cycle %0d expected 0", d_gnt); end
        checks++; if (d_ok < 0 || i_gnt < d_ok) begin fails++; $display("FAIL arb_inst_wait: got inst grant %0d data_ok %0d", i_gnt, d_ok); end
        checks++; if (ids.size() != 2 || ids[0] !== 4'd1 || ids[1] !== 4'd0) begin fails++; $display("FAIL arb_ids: got %0d ids first %0d", ids.size(), ids.size() > 0 ? ids[0] : 4'hF); end
        checks++; if (d_rd !== ref_rd(32'h2000 >> 2)) begin fails++; $display("FAIL arb_data_rdata: got %h expected %h", d_rd, ref_rd(32'h2000 >> 2)); end
        checks++; if (i_rd !== ref_rd(32'h3000 >> 2) || i_ok !== i_gnt + 3) begin fails++; $display("FAIL arb_inst_rdata: got %h at %0d expected %h at %0d", i_rd, i_ok, ref_rd(32'h3000 >> 2), i_gnt + 3); end
    endtask

    task automatic test_byte_store;
        int lat; logic [31:0] rd; bit ok;
        set_delays(0, 0, 0, 2, 1);
        do_req(1, 1, 2'd0, 32'h80000003, 32'hAB000000, lat, rd, ok);
        ref_store(32'h80000003, 2'd0, 32'hAB000000);
        checks++; if (!ok || lat !== 6) begin fails++; $display("FAIL store_latency: got ok %0d lat %0d expected 1 6", ok, lat); end
        checks++; if (wr_size !== 3'd0 || wr_addr !== 32'h80000003) begin fails++; $display("FAIL store_aw: got size %0d addr %h expected 0 80000003", wr_size, wr_addr); end
        checks++; if (wr_strb !== 4'b1000 || wr_data !== 32'hAB000000) begin fails++; $display("FAIL store_w: got strb %b data %h expected 1000 ab000000", wr_strb, wr_data); end
        checks++; if (aw_hs_cyc == w_hs_cyc) begin fails++; $display("FAIL store_split_hs: got aw %0d w %0d expected different", aw_hs_cyc, w_hs_cyc); end
        set_delays(0, 0, 0, 0, 0);
        do_req(1, 0, 2'd2, 32'h80000000, '0, lat, rd, ok);
        checks++; if (!ok || rd !== ref_rd(32'h80000000 >> 2)) begin fails++; $display("FAIL store_readback: got %h expected %h", rd, ref_rd(32'h80000000 >> 2)); end
    endtask

    task automatic test_delayed_slave;
        int lat, c0; logic [31:0] rd; bit ok;
        set_delays(5, 7, 0, 0, 0);
        ar_unstable = 0;
        c0 = data_ok_cnt;
        do_req(1, 0, 2'd2, 32'h1234, '0, lat, rd, ok);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (!ok || lat !== 15) begin fails++; $display("FAIL delayed_latency: got ok %0d lat %0d expected 1 15", ok, lat); end
        checks++; if (rd !== ref_rd(32'h1234 >> 2)) begin fails++; $display("FAIL delayed_rdata: got %h expected %h", rd, ref_rd(32'h1234 >> 2)); end
        checks++; if (ar_unstable !== 1'b0) begin fails++; $display("FAIL delayed_ar_stable: got unstable %0d expected 0", ar_unstable); end
        checks++; if (data_ok_cnt - c0 !== 1) begin fails++; $display("FAIL delayed_one_ok: got %0d pulses expected 1", data_ok_cnt - c0); end
    endtask

    task automatic test_reset_mid;
        int ci, cd, lat; logic [31:0] rd; bit ok, in_r = 0;
        set_delays(0, 20, 0, 0, 0);
        inst_req = 1; inst_addr = 32'h400;
        @(negedge clk);
        @(posedge clk); #1;
        inst_req = 0;
        for (int k = 0; k < 10 && !in_r; k++) begin
            @(negedge clk);
            in_r = axi.rready;
        end
        checks++; if (!in_r) begin fails++; $display("FAIL rstmid_reach_r: got rready 0 expected 1"); end
        #2 rst = 1;
        #1;
        checks++; if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, inst_data_ok, data_data_ok} !== 7'b0) begin fails++; $display("FAIL rstmid_outputs: got %b expected 0000000", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, inst_data_ok, data_data_ok}); end
        checks++; if (inst_rdata !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL rstmid_rdata_err: got %h %b expected 0 0", inst_rdata, err); end
        ci = inst_ok_cnt; cd = data_ok_cnt;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
        repeat (25) @(posedge clk);
        #1;
        checks++; if (inst_ok_cnt !== ci || data_ok_cnt !== cd) begin fails++; $display("FAIL rstmid_no_ok: got %0d/%0d pulses expected 0", inst_ok_cnt - ci, data_ok_cnt - cd); end
        set_delays(0, 0, 0, 0, 0);
        do_req(0, 0, 2'd2, 32'h400, '0, lat, rd, ok);
        checks++; if (!ok || lat !== 3 || rd !== ref_rd(32'h400 >> 2)) begin fails++; $display("FAIL rstmid_recover: got lat %0d data %h expected 3 %h", lat, rd, ref_rd(32'h400 >> 2)); end
    endtask

    task automatic test_random;
        for (int t = 0; t < 60; t++) begin
            bit d, wr, ok;
            logic [1:0] sz;
            logic [31:0] a, wd, rd;
            int lat, exp_lat, ar, r, aw, w, b;
            d = 1'($urandom_range(0, 1));
            wr = d ? 1'($urandom_range(0, 1)) : 1'b0;
            sz = d ? 2'($urandom_range(0, 3)) : 2'd2;
            a = 32'h10000 + 32'($urandom_range(0, 15)) * 4;
            if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
            if (sz == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
            wd = $urandom;
            ar = $urandom_range(0, 3); r = $urandom_range(0, 3);
            aw = $urandom_range(0, 3); w = $urandom_range(0, 3); b = $urandom_range(0, 3);
            set_delays(ar, r, aw, w, b);
            exp_lat = wr ? 3 + (aw > w ? aw : w) + b : 3 + ar + r;
            do_req(d, wr, sz, a, wd, lat, rd, ok);
            checks++; if (!ok || lat !== exp_lat) begin fails++; $display("FAIL rand_latency[%0d]: got ok %0d lat %0d expected %0d", t, ok, lat, exp_lat); end
            if (wr) ref_store(a, sz == 2'd3 ? 2'd2 : sz, wd);
            else begin
                checks++; if (rd !== ref_rd(int'(a[31:2]))) begin fails++; $display("FAIL rand_rdata[%0d]: got %h expected %h addr %h", t, rd, ref_rd(int'(a[31:2])), a); end
            end
        end
    endtask

`ifdef SRAM_AXI_TIMEOUT_EN
    task automatic test_timeout;
        int lat; logic [31:0] rd; bit ok;
        set_delays(0, 0, 0, 0, 0);
        r_hang = 1;
        do_req(1, 0, 2'd2, 32'h500, '0, lat, rd, ok);
        r_hang = 0;
        checks++; if (!ok || lat < 255 || lat > 260) begin fails++; $display("FAIL timeout_latency: got ok %0d lat %0d expected about 255", ok, lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL timeout_rdata: got %h expected deadbeef", rd); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err_sticky: got %b expected 1", err); end
        rst = 1;
        #1;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL timeout_err_clear: got %b expected 0", err); end
        @(negedge clk);
        @(posedge clk); #1;
        rst = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_inst_read();
        test_arbitration();
        test_byte_store();
        test_delayed_slave();
        test_reset_mid();
        test_random();
`ifdef SRAM_AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", checks, fails);
        $fatal(1);
    end
endmodule
